spio_hss_multiplexer_pkt_rx_seq: RTL and testbench
==================================================

Name: spio_hss_multiplexer_pkt_rx_seq

Overview:
- Receive-side counterpart of the transmit packet store.
- Takes decoded frames (sequence number, payload, CRC status) from the frame disassembler and accepts only in-order, error-free frames into a local packet FIFO.
- Generates the ack/nak indications, with ack_seq semantics identical to the transmitter's, and drives the local channel flow-control bit that the transmitter sees as cfc_rem.
- Presents accepted packets to the router side on a vld/rdy interface.

Parameters:
- PKT_BITS, 72: packet payload width.
- SEQ_BITS, 7: frame sequence number width.
- FIFO_BITS, 3: log2 of receive FIFO depth (depth = 8).
- CFC_MARGIN, 2: free slots reserved for frames already in flight when cfc_loc drops.
- ACK_TIMEOUT, 16: cycles from first unacknowledged accept to forced ack; also the nak re-issue interval.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- frm_vld  in  1  one-cycle frame strobe from disassembler. No backpressure.
- frm_seq  in  SEQ_BITS  frame sequence number.
- frm_data  in  PKT_BITS  frame payload.
- frm_err  in  1  CRC/format error on this frame.
- pkt_data  out  PKT_BITS  FIFO head packet.
- pkt_vld  out  1  FIFO head valid.
- pkt_rdy  in  1  consumer ready.
- ack_vld  out  1  one-cycle ack strobe.
- nak_vld  out  1  one-cycle nak strobe.
- ack_seq  out  SEQ_BITS  next expected sequence. All earlier frames are acknowledged; on nak, this frame is to be resent.
- cfc_loc  out  1  local flow control; 1 = transmitter may send.
- empty  out  1  FIFO empty (status).
- full  out  1  FIFO full (status).

Behaviour:
- Reset values: exp_seq=0, state=RUN, FIFO empty, pkt_vld=0, ack_vld=0, nak_vld=0, ack_seq=0, cfc_loc=0, empty=1, full=0, ack_pend=0, timer=0.
- good = frm_vld && !frm_err && frm_seq==exp_seq && !full. full is the registered flag; a same-cycle pop does not free the slot.
- On good: write FIFO, exp_seq <= exp_seq+1 (mod 2^SEQ_BITS, wraps 127->0), set ack_pend. pkt_vld rises the cycle after the write.
- FSM RUN:
  - frm_vld && !good (error, wrong sequence, or full): issue nak, go NAK_WAIT. The frame is dropped.
- FSM NAK_WAIT:
  - Non-good frames are discarded silently.
  - good: accept as in RUN, go RUN.
  - Timer reaches ACK_TIMEOUT-1 with no good frame: re-issue nak, timer restarts.
- Ack/nak outputs are registered, asserted 1 cycle after the triggering event, one cycle wide. ack_seq carries the exp_seq value after the event.
- Ack issue: ack_pend && (timer==ACK_TIMEOUT-1 || no frm_vld this cycle). Clears ack_pend and the timer.
- Nak priority: nak has priority over ack in the same cycle. A nak implicitly acks and clears ack_pend.
- Never assert ack_vld and nak_vld together.
- Packet output: pkt_vld = !empty; pkt_data = FIFO[rd_ptr]. Pop on pkt_vld && pkt_rdy.
- Simultaneous push and pop: both occur; count unchanged.
- cfc_loc (registered): cfc_loc <= (free slots after this cycle's push/pop) > CFC_MARGIN. It is 1 the first cycle after reset.
- Pointers are FIFO_BITS wide with an extra wrap bit for full/empty disambiguation.
- Reset mid-operation: all state is cleared and FIFO contents are discarded. The transmitter recovers via its nak/timeout path.

Optional Feature:
- Macro: SPIO_PKT_RX_SEQ_STATS_EN.
- When defined: adds outputs nak_cnt[15:0] (naks issued, including re-issues) and drop_cnt[15:0] (frames discarded for any reason). Both saturate at 0xFFFF and reset to 0.
- When undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared header/package: PKT_BITS, SEQ_BITS, FSM state encodings (RUN, NAK_WAIT), and the ack/nak strobe bundle definition shared with the transmit packet store.
- One sub-module: spio_hss_multiplexer_rx_fifo (synchronous FIFO with vld/rdy read, push, full/empty, and free-slot count). The FSM and ack logic stay in the top level.

Test Plan:
- In-order frames seq 0..4, pkt_rdy=1: pkt_vld sequence with data matching, ack_vld pulse with ack_seq=5, no nak.
- Frame seq 2 arrives when 1 is expected: nak_vld next cycle with ack_seq=1. Seq 3,4 are then dropped with no further nak. Seq 1 is accepted; state returns to RUN.
- frm_err=1 on the expected seq 0: nak with ack_seq=0. No retransmit for ACK_TIMEOUT cycles: a second nak with ack_seq=0.
- pkt_rdy=0, push 8 frames:
  - cfc_loc drops when free slots reach 2.
  - full=1 after 8 pushes.
  - A 9th in-sequence frame is dropped and naked with ack_seq=8.
  - Push and pop on the same cycle keep the count constant.
- 130 in-order frames: exp_seq wraps 127->0 and the final ack_seq=2.
- Assert rst_n low mid-stream with the FIFO at 3 entries: outputs take their reset values immediately; after release, frame seq 0 is accepted.

Source files
------------

// File: rtl/spio_hss_multiplexer_pkt_rx_seq_pkg.sv
// Shared definitions for the HSS multiplexer receive sequencer: default widths,
// receive FSM encoding and the ack/nak strobe pair also used by the transmit store.
package spio_hss_multiplexer_pkt_rx_seq_pkg;

  localparam int PKT_BITS    = 72;
  localparam int SEQ_BITS    = 7;
  localparam int FIFO_BITS   = 3;
  localparam int CFC_MARGIN  = 2;
  localparam int ACK_TIMEOUT = 16;

  typedef enum logic {
    RUN      = 1'b0,
    NAK_WAIT = 1'b1
  } rx_state_t;

  typedef struct packed {
    logic ack;
    logic nak;
  } ack_nak_t;

endpackage

// File: rtl/spio_hss_multiplexer_rx_fifo.sv
// Receive packet FIFO: head is visible combinationally, pops on rd_vld && rd_rdy,
// and reports the free-slot count that will hold after this cycle's push/pop.
module spio_hss_multiplexer_rx_fifo #(
  parameter int DATA_BITS = 72,
  parameter int ADDR_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_data,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_vld,
  input  logic                 rd_rdy,
  output logic                 empty,
  output logic                 full,
  output logic [ADDR_BITS:0]   free_next
);
  import spio_hss_multiplexer_pkt_rx_seq_pkg::*;

  localparam int                 DEPTH   = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] ONE     = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS+1)'(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [ADDR_BITS:0]   wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_BITS:0]   count, count_next;
  logic                 push_ok, pop;

  // Extra MSB on each pointer separates "wrapped and equal" (full) from "equal" (empty).
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[ADDR_BITS] != rd_ptr_reg[ADDR_BITS]) &&
                   (wr_ptr_reg[ADDR_BITS-1:0] == rd_ptr_reg[ADDR_BITS-1:0]);
  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign rd_vld  = !empty;
  assign rd_data = mem[rd_ptr_reg[ADDR_BITS-1:0]];
  assign push_ok = push && !full;
  assign pop     = rd_vld && rd_rdy;

  always_comb begin
    count_next = count;
    if (push_ok && !pop) begin
      count_next = count + ONE;
    end else if (!push_ok && pop) begin
      count_next = count - ONE;
    end
  end

  assign free_next = DEPTH_W - count_next;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[ADDR_BITS-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + ONE;
      end
    end
  end

endmodule

// File: rtl/spio_hss_multiplexer_pkt_rx_seq.sv
// Receive sequencer: accepts in-order error-free frames, generates ack/nak and cfc_loc.
// Optional SPIO_PKT_RX_SEQ_STATS_EN adds saturating nak_cnt / drop_cnt outputs.
module spio_hss_multiplexer_pkt_rx_seq #(
  parameter int PKT_BITS    = spio_hss_multiplexer_pkt_rx_seq_pkg::PKT_BITS,
  parameter int SEQ_BITS    = spio_hss_multiplexer_pkt_rx_seq_pkg::SEQ_BITS,
  parameter int FIFO_BITS   = spio_hss_multiplexer_pkt_rx_seq_pkg::FIFO_BITS,
  parameter int CFC_MARGIN  = spio_hss_multiplexer_pkt_rx_seq_pkg::CFC_MARGIN,
  parameter int ACK_TIMEOUT = spio_hss_multiplexer_pkt_rx_seq_pkg::ACK_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frm_vld,
  input  logic [SEQ_BITS-1:0] frm_seq,
  input  logic [PKT_BITS-1:0] frm_data,
  input  logic                frm_err,
  output logic [PKT_BITS-1:0] pkt_data,
  output logic                pkt_vld,
  input  logic                pkt_rdy,
  output logic                ack_vld,
  output logic                nak_vld,
  output logic [SEQ_BITS-1:0] ack_seq,
  output logic                cfc_loc,
  output logic                empty,
  output logic                full
`ifdef SPIO_PKT_RX_SEQ_STATS_EN
  ,
  output logic [15:0]         nak_cnt,
  output logic [15:0]         drop_cnt
`endif
);
  import spio_hss_multiplexer_pkt_rx_seq_pkg::*;

  localparam int                 TMR_BITS = $clog2(ACK_TIMEOUT);
  localparam logic [TMR_BITS-1:0] TMR_LAST = TMR_BITS'(ACK_TIMEOUT - 1);
  localparam logic [TMR_BITS-1:0] TMR_ONE  = TMR_BITS'(1);
  localparam logic [SEQ_BITS-1:0] SEQ_ONE  = SEQ_BITS'(1);
  localparam logic [FIFO_BITS:0]  MARGIN   = (FIFO_BITS+1)'(CFC_MARGIN);

  rx_state_t           state_reg, state_next;
  logic [SEQ_BITS-1:0] exp_seq_reg, exp_seq_next;
  logic                ack_pend_reg, ack_pend_next;
  logic [TMR_BITS-1:0] timer_reg, timer_next;
  ack_nak_t            strobe_reg, strobe_next;
  logic [SEQ_BITS-1:0] ack_seq_reg;
  logic                cfc_reg;
  logic                good, drop;
  logic [FIFO_BITS:0]  free_next;

  // full here is the registered FIFO flag, so a same-cycle pop never frees a slot.
  assign good = frm_vld && !frm_err && (frm_seq == exp_seq_reg) && !full;
  assign drop = frm_vld && !good;

  spio_hss_multiplexer_rx_fifo #(
    .DATA_BITS (PKT_BITS),
    .ADDR_BITS (FIFO_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (good),
    .push_data (frm_data),
    .rd_data   (pkt_data),
    .rd_vld    (pkt_vld),
    .rd_rdy    (pkt_rdy),
    .empty     (empty),
    .full      (full),
    .free_next (free_next)
  );

  always_comb begin
    state_next    = state_reg;
    exp_seq_next  = good ? exp_seq_reg + SEQ_ONE : exp_seq_reg;
    strobe_next   = '0;
    ack_pend_next = ack_pend_reg || good;
    timer_next    = timer_reg;

    case (state_reg)
      RUN: begin
        if (drop) begin
          strobe_next.nak = 1'b1;
          state_next      = NAK_WAIT;
        end
      end
      NAK_WAIT: begin
        if (good) begin
          state_next = RUN;
        end else if (timer_reg == TMR_LAST) begin
          strobe_next.nak = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase

    // A nak also acknowledges everything before ack_seq, so it wins over an ack.
    if (!strobe_next.nak && ack_pend_reg && (timer_reg == TMR_LAST || !frm_vld)) begin
      strobe_next.ack = 1'b1;
    end

    if (strobe_next.ack || strobe_next.nak) begin
      ack_pend_next = 1'b0;
      timer_next    = '0;
    end else if (state_reg == NAK_WAIT && good) begin
      timer_next = '0;
    end else if (ack_pend_reg || state_reg == NAK_WAIT) begin
      timer_next = timer_reg + TMR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= RUN;
      exp_seq_reg  <= '0;
      ack_pend_reg <= 1'b0;
      timer_reg    <= '0;
      strobe_reg   <= '0;
      ack_seq_reg  <= '0;
      cfc_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      exp_seq_reg  <= exp_seq_next;
      ack_pend_reg <= ack_pend_next;
      timer_reg    <= timer_next;
      strobe_reg   <= strobe_next;
      if (strobe_next.ack || strobe_next.nak) begin
        ack_seq_reg <= exp_seq_next;
      end
      cfc_reg <= (free_next > MARGIN);
    end
  end

  assign ack_vld = strobe_reg.ack;
  assign nak_vld = strobe_reg.nak;
  assign ack_seq = ack_seq_reg;
  assign cfc_loc = cfc_reg;

`ifdef SPIO_PKT_RX_SEQ_STATS_EN
  logic [15:0] nak_cnt_reg, drop_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nak_cnt_reg  <= '0;
      drop_cnt_reg <= '0;
    end else begin
      if (strobe_next.nak && nak_cnt_reg != 16'hFFFF) begin
        nak_cnt_reg <= nak_cnt_reg + 16'd1;
      end
      if (drop && drop_cnt_reg != 16'hFFFF) begin
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
    end
  end

  assign nak_cnt  = nak_cnt_reg;
  assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_spio_hss_multiplexer_pkt_rx_seq.sv
// Self-checking bench for spio_hss_multiplexer_pkt_rx_seq: vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_spio_hss_multiplexer_pkt_rx_seq;

  localparam int PB     = 72;
  localparam int SB     = 7;
  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;
  localparam int TMO    = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          frm_vld = 1'b0;
  logic [SB-1:0] frm_seq = '0;
  logic [PB-1:0] frm_data = '0;
  logic          frm_err = 1'b0;
  logic [PB-1:0] pkt_data;
  logic          pkt_vld;
  logic          pkt_rdy = 1'b0;
  logic          ack_vld, nak_vld;
  logic [SB-1:0] ack_seq;
  logic          cfc_loc, empty, full;
`ifdef SPIO_PKT_RX_SEQ_STATS_EN
  logic [15:0]   nak_cnt, drop_cnt;
`endif

  always #5 clk = ~clk;

  spio_hss_multiplexer_pkt_rx_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .frm_vld  (frm_vld),
    .frm_seq  (frm_seq),
    .frm_data (frm_data),
    .frm_err  (frm_err),
    .pkt_data (pkt_data),
    .pkt_vld  (pkt_vld),
    .pkt_rdy  (pkt_rdy),
    .ack_vld  (ack_vld),
    .nak_vld  (nak_vld),
    .ack_seq  (ack_seq),
    .cfc_loc  (cfc_loc),
    .empty    (empty),
    .full     (full)
`ifdef SPIO_PKT_RX_SEQ_STATS_EN
    ,
    .nak_cnt  (nak_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: receiver behaviour expressed with a queue and integers.
  int            m_exp;
  logic [PB-1:0] m_q[$];
  bit            m_pend, m_nakwait, m_ack, m_nak, m_cfc;
  int            m_tmr, m_seq, m_naks, m_drops;

  typedef struct {
    bit rst;
    bit v;
    int seq;
    bit x_pv;
    bit x_ack;
    bit x_nak;
    int x_seq;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [PB-1:0] mk(input int s);
    return {8'(s), 32'hDEADBEEF ^ 32'(s), 32'(s * 7 + 1)};
  endfunction

  task automatic chk(input string name, input logic [PB-1:0] act, input logic [PB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_exp = 0;
    m_q.delete();
    m_pend = 0; m_nakwait = 0; m_ack = 0; m_nak = 0; m_cfc = 0;
    m_tmr = 0; m_seq = 0; m_naks = 0; m_drops = 0;
  endtask

  task automatic check_outputs();
    chk("pkt_vld", pkt_vld, m_q.size() != 0);
    if (m_q.size() != 0) chk("pkt_data", pkt_data, m_q[0]);
    chk("empty", empty, m_q.size() == 0);
    chk("full", full, m_q.size() == DEPTH);
    chk("ack_vld", ack_vld, m_ack);
    chk("nak_vld", nak_vld, m_nak);
    chk("ack_seq", ack_seq, m_seq);
    chk("cfc_loc", cfc_loc, m_cfc);
`ifdef SPIO_PKT_RX_SEQ_STATS_EN
    chk("nak_cnt", nak_cnt, m_naks);
    chk("drop_cnt", drop_cnt, m_drops);
`endif
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input bit v, input int s, input logic [PB-1:0] d, input bit e, input bit r);
    bit good, pop, ack, nak;
    frm_vld = v; frm_seq = SB'(s); frm_data = d; frm_err = e; pkt_rdy = r;
    good = v && !e && (s == m_exp) && (m_q.size() < DEPTH);
    pop  = (m_q.size() > 0) && r;
    nak  = m_nakwait ? (!good && m_tmr == TMO - 1) : (v && !good);
    ack  = !nak && m_pend && (m_tmr == TMO - 1 || !v);
    if (pop) void'(m_q.pop_front());
    if (good) begin
      m_q.push_back(d);
      m_exp = (m_exp + 1) % 128;
    end
    m_ack = ack;
    m_nak = nak;
    if (ack || nak) begin
      m_seq  = m_exp;
      m_pend = 0;
      m_tmr  = 0;
    end else begin
      if (m_nakwait && good) m_tmr = 0;
      else if (m_pend || m_nakwait) m_tmr++;
      m_pend = m_pend || good;
    end
    if (nak) m_nakwait = 1;
    else if (good) m_nakwait = 0;
    m_cfc = (DEPTH - m_q.size()) > MARGIN;
    m_naks += int'(nak);
    m_drops += int'(v && !good);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    frm_vld = 0; frm_err = 0; frm_seq = '0; frm_data = '0; pkt_rdy = 0;
    #1;
    chk("rst_pkt_vld", pkt_vld, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ack_vld", ack_vld, 0);
    chk("rst_nak_vld", nak_vld, 0);
    chk("rst_ack_seq", ack_seq, 0);
    chk("rst_cfc_loc", cfc_loc, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    check_outputs();
  endtask

  initial begin
    // {rst, vld, seq, exp pkt_vld, exp ack, exp nak, exp ack_seq}
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 1, 0, 0, 0};
    tbl[2]  = '{0, 1, 1, 1, 0, 0, 0};
    tbl[3]  = '{0, 1, 2, 1, 0, 0, 0};
    tbl[4]  = '{0, 1, 3, 1, 0, 0, 0};
    tbl[5]  = '{0, 1, 4, 1, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 1, 0, 5};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 5};
    tbl[8]  = '{1, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{0, 1, 0, 1, 0, 0, 0};
    tbl[10] = '{0, 1, 2, 0, 0, 1, 1};
    tbl[11] = '{0, 1, 3, 0, 0, 0, 1};
    tbl[12] = '{0, 1, 4, 0, 0, 0, 1};
    tbl[13] = '{0, 1, 1, 1, 0, 0, 1};
    tbl[14] = '{0, 0, 0, 0, 1, 0, 2};
    tbl[15] = '{0, 1, 3, 0, 0, 1, 2};

    model_reset();
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].rst) begin
        do_reset();
      end else begin
        step(tbl[i].v, tbl[i].seq, mk(tbl[i].seq), 1'b0, 1'b1);
        chk("tbl_pkt_vld", pkt_vld, tbl[i].x_pv);
        chk("tbl_ack_vld", ack_vld, tbl[i].x_ack);
        chk("tbl_nak_vld", nak_vld, tbl[i].x_nak);
        chk("tbl_ack_seq", ack_seq, tbl[i].x_seq);
        if (tbl[i].x_pv) chk("tbl_pkt_data", pkt_data, mk(tbl[i].seq));
      end
    end

    // CRC error on the expected frame, then nak re-issue after ACK_TIMEOUT idle cycles.
    do_reset();
    step(1, 0, mk(0), 1, 1);
    chk("err_nak", nak_vld, 1);
    chk("err_nak_seq", ack_seq, 0);
    for (int i = 0; i < TMO - 1; i++) step(0, 0, '0, 0, 1);
    step(0, 0, '0, 0, 1);
    chk("renak", nak_vld, 1);
    chk("renak_seq", ack_seq, 0);

    // Fill with consumer stalled: cfc drop, full, overflow nak, push+pop.
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      step(1, k, mk(k), 0, 0);
      chk("fill_cfc", cfc_loc, (DEPTH - (k + 1)) > MARGIN);
    end
    chk("fill_full", full, 1);
    step(1, 8, mk(8), 0, 0);
    chk("ovf_nak", nak_vld, 1);
    chk("ovf_seq", ack_seq, 8);
    chk("ovf_full", full, 1);
    step(0, 0, '0, 0, 1);
    step(1, 8, mk(8), 0, 1);
    chk("pp_full", full, 0);
    chk("pp_head", pkt_data, mk(2));
    for (int i = 0; i < DEPTH - 2; i++) step(0, 0, '0, 0, 1);
    chk("pp_not_empty", empty, 0);
    chk("pp_last", pkt_data, mk(8));
    step(0, 0, '0, 0, 1);
    chk("pp_drained", empty, 1);

    // Sequence number wrap over 130 frames.
    do_reset();
    for (int k = 0; k < 130; k++) step(1, k % 128, mk(k), 0, 1);
    step(0, 0, '0, 0, 1);
    chk("wrap_ack", ack_vld, 1);
    chk("wrap_seq", ack_seq, 2);

    // Asynchronous reset with 3 packets stored and an ack on the output.
    do_reset();
    for (int k = 0; k < 3; k++) step(1, k, mk(k), 0, 0);
    step(0, 0, '0, 0, 0);
    chk("pre_rst_ack_seq", ack_seq, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pkt_vld", pkt_vld, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_ack_vld", ack_vld, 0);
    chk("mid_rst_ack_seq", ack_seq, 0);
    chk("mid_rst_cfc", cfc_loc, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    check_outputs();
    step(1, 0, mk(100), 0, 0);
    chk("post_rst_pkt_vld", pkt_vld, 1);
    chk("post_rst_data", pkt_data, mk(100));

    // Randomized traffic: mostly expected seq, some skips, errors and backpressure.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int r;
      int s;
      bit v, e, rdy;
      logic [PB-1:0] d;
      r = int'($urandom_range(0, 9));
      v = ($urandom_range(0, 3) != 0);
      s = (r < 6) ? m_exp : (r < 8) ? (m_exp + 1) % 128 : int'($urandom_range(0, 127));
      e = ($urandom_range(0, 11) == 0);
      rdy = ((i / 300) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      d = {8'($urandom), $urandom, $urandom};
      step(v, s, d, e, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
